// File: rtl/manchester_byte_decoder_if.sv
// Byte output channel of the Manchester decoder.
// Handshake: the producer raises byte_valid with byte_data stable and keeps
// both unchanged until the consumer is ready. A transfer happens on every
// rising clock edge where byte_valid && byte_ready are both high. The producer
// may load a new byte on the same edge as a transfer.
interface manchester_byte_decoder_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/manchester_byte_decoder.sv
// Manchester byte decoder: samples the line in both halves of each bit, as
// marked by the recovered half-bit clock. It rejects bits without a mid-bit
// transition and packs the bits LSB-first into bytes. Each byte goes out
// through a single-entry holding register.
module manchester_byte_decoder #(
    parameter int TIMEOUT = 64
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             digital_in,
    input  logic                             manchester_clock,
    manchester_byte_decoder_if.master        byte_out,
    output logic                             receiving,
    output logic                             overrun,
    output logic [7:0]                       code_errors,
    output logic [1:0]                       state_dbg
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        WAIT_A = 2'd1,
        WAIT_B = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic       mclk_q;
    logic       half_a;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic [7:0] tmo_cnt;

    logic toggle;
    logic rise_t;
    logic fall_t;
    logic bit_good;
    logic bit_bad;
    logic byte_done;
    logic tmo_hit;
    logic accept;
    logic capture_a;

    assign toggle    = manchester_clock ^ mclk_q;
    assign rise_t    = toggle & manchester_clock;
    assign fall_t    = toggle & ~manchester_clock;
    assign bit_good  = (state == WAIT_B) && fall_t && (half_a != digital_in);
    assign bit_bad   = (state == WAIT_B) && fall_t && (half_a == digital_in);
    assign byte_done = bit_good && (bit_cnt == 3'd7);
    // A toggle in the same cycle always wins over an expiring idle counter.
    assign tmo_hit   = (state != HUNT) && !toggle && (tmo_cnt == TMO_LAST);
    assign accept    = byte_out.byte_valid && byte_out.byte_ready;
    assign capture_a = rise_t && (state == HUNT || state == WAIT_A);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= HUNT;
        else       state <= state_next;
    end

    // Next-state logic: track which half of the bit period comes next.
    always_comb begin
        state_next = state;
        case (state)
            HUNT:    if (rise_t) state_next = WAIT_B;
            WAIT_B:  begin
                if (bit_good)     state_next = WAIT_A;
                else if (bit_bad) state_next = HUNT;
                else if (tmo_hit) state_next = HUNT;
            end
            WAIT_A:  begin
                if (rise_t)       state_next = WAIT_B;
                else if (tmo_hit) state_next = HUNT;
            end
            default: state_next = HUNT;
        endcase
    end

    // FSM outputs.
    always_comb begin
        receiving = (state != HUNT);
        state_dbg = state;
    end

    // Bit assembly: half-bit capture, shift register, bit counter, idle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            mclk_q    <= 1'b0;
            half_a    <= 1'b0;
            shift_reg <= 8'd0;
            bit_cnt   <= 3'd0;
            tmo_cnt   <= 8'd0;
        end else begin
            mclk_q <= manchester_clock;
            if (capture_a) half_a <= digital_in;

            if (bit_good) begin
                shift_reg <= {half_a, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end else if (bit_bad || tmo_hit) begin
                shift_reg <= 8'd0;
                bit_cnt   <= 3'd0;
            end

            if (state == HUNT || toggle || tmo_hit) tmo_cnt <= 8'd0;
            else                                    tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Holding register, overrun flag and saturating violation counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_out.byte_data  <= 8'd0;
            byte_out.byte_valid <= 1'b0;
            overrun             <= 1'b0;
            code_errors         <= 8'd0;
        end else begin
            if (byte_done && (!byte_out.byte_valid || byte_out.byte_ready)) begin
                byte_out.byte_data  <= {half_a, shift_reg[7:1]};
                byte_out.byte_valid <= 1'b1;
            end else begin
                if (byte_done) overrun <= 1'b1;
                if (accept)    byte_out.byte_valid <= 1'b0;
            end

            if (bit_bad && code_errors != 8'hFF) code_errors <= code_errors + 8'd1;
        end
    end

endmodule

// File: tb/tb_manchester_byte_decoder.sv
// Directed bench for manchester_byte_decoder with a reference model that is
// compared every cycle, plus literal byte/flag expectations.
module tb_manchester_byte_decoder;

    localparam int TIMEOUT = 64;
    localparam int P_HUNT  = 0;
    localparam int P_SECOND = 1;
    localparam int P_FIRST  = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       digital_in;
    logic       manchester_clock;
    logic       receiving;
    logic       overrun;
    logic [7:0] code_errors;
    logic [1:0] state_dbg;

    manchester_byte_decoder_if bus ();

    manchester_byte_decoder #(.TIMEOUT(TIMEOUT)) dut (
        .clock            (clock),
        .reset            (reset),
        .digital_in       (digital_in),
        .manchester_clock (manchester_clock),
        .byte_out         (bus),
        .receiving        (receiving),
        .overrun          (overrun),
        .code_errors      (code_errors),
        .state_dbg        (state_dbg)
    );

    // Clock generation.
    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         valid_cycles = 0;
    logic       armed = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic       m_prev = 1'b0;
    int         m_phase = P_HUNT;
    logic       m_half = 1'b0;
    int         m_acc = 0;
    int         m_n = 0;
    int         m_idle = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'd0;
    logic       m_overrun = 1'b0;
    int         m_errors = 0;

    // Model: consume half-bit events, collect bits into an integer word.
    always @(posedge clock) begin : ref_model
        logic       tog, rise, fall, v, ovr, half;
        int         ph, acc, n, idle, errs;
        logic [7:0] dat;
        if (reset) begin
            m_prev    <= 1'b0;
            m_phase   <= P_HUNT;
            m_half    <= 1'b0;
            m_acc     <= 0;
            m_n       <= 0;
            m_idle    <= 0;
            m_valid   <= 1'b0;
            m_data    <= 8'd0;
            m_overrun <= 1'b0;
            m_errors  <= 0;
        end else begin
            tog  = (manchester_clock != m_prev);
            rise = tog && manchester_clock;
            fall = tog && !manchester_clock;
            ph = m_phase; acc = m_acc; n = m_n; idle = m_idle; errs = m_errors;
            v = m_valid; ovr = m_overrun; dat = m_data; half = m_half;
            if (m_valid && bus.byte_ready) v = 1'b0;
            if ((ph == P_HUNT || ph == P_FIRST) && rise) begin
                half = digital_in;
                ph   = P_SECOND;
            end else if (ph == P_SECOND && fall) begin
                if (digital_in != half) begin
                    acc = acc + (int'(half) << n);
                    n   = n + 1;
                    if (n == 8) begin
                        if (!m_valid || bus.byte_ready) begin
                            v   = 1'b1;
                            dat = acc[7:0];
                        end else begin
                            ovr = 1'b1;
                        end
                        acc = 0;
                        n   = 0;
                    end
                    ph = P_FIRST;
                end else begin
                    if (errs < 255) errs = errs + 1;
                    acc = 0;
                    n   = 0;
                    ph  = P_HUNT;
                end
            end
            if (m_phase == P_HUNT || tog) begin
                idle = 0;
            end else if (idle + 1 == TIMEOUT) begin
                idle = 0;
                ph   = P_HUNT;
                acc  = 0;
                n    = 0;
            end else begin
                idle = idle + 1;
            end
            m_prev    <= manchester_clock;
            m_phase   <= ph;
            m_half    <= half;
            m_acc     <= acc;
            m_n       <= n;
            m_idle    <= idle;
            m_valid   <= v;
            m_data    <= dat;
            m_overrun <= ovr;
            m_errors  <= errs;
        end
    end

    // Compare process and scoreboard, sampled on the falling edge.
    always @(negedge clock) begin
        if (armed) begin
            check("byte_valid", 32'(bus.byte_valid), 32'(m_valid));
            check("byte_data", 32'(bus.byte_data), 32'(m_data));
            check("overrun", 32'(overrun), 32'(m_overrun));
            check("code_errors", 32'(code_errors), 32'(m_errors));
            check("receiving", 32'(receiving), 32'(m_phase != P_HUNT));
            if (bus.byte_valid === 1'b1) valid_cycles++;
            if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(bus.byte_data), 32'hFFFF_FFFF);
                end else begin
                    check("sb_byte", 32'(bus.byte_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        digital_in       = b;
        manchester_clock = 1'b1;
        cycles(gap);
        digital_in       = !b;
        manchester_clock = 1'b0;
        cycles(gap);
    endtask

    task automatic send_viol(input logic level, input int gap);
        digital_in       = level;
        manchester_clock = 1'b1;
        cycles(gap);
        manchester_clock = 1'b0;
        cycles(gap);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < 8; i++) send_bit(b[i], gap);
    endtask

    // Directed stimulus.
    initial begin
        logic [7:0] v;
        reset            = 1'b1;
        digital_in       = 1'b0;
        manchester_clock = 1'b0;
        bus.byte_ready   = 1'b0;
        cycles(3);
        armed = 1'b1;
        reset = 1'b0;
        check("rst_valid", 32'(bus.byte_valid), 32'd0);
        check("rst_data", 32'(bus.byte_data), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_errors", 32'(code_errors), 32'd0);
        check("rst_receiving", 32'(receiving), 32'd0);
        cycles(100);
        check("idle_receiving", 32'(receiving), 32'd0);
        check("idle_valid", 32'(bus.byte_valid), 32'd0);

        // Single byte 0xA5 (bits 1,0,1,0,0,1,0,1), consumer always ready.
        bus.byte_ready = 1'b1;
        valid_cycles   = 0;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 4);
        cycles(4);
        check("a5_valid_cycles", 32'(valid_cycles), 32'd1);
        check("a5_overrun", 32'(overrun), 32'd0);
        check("a5_errors", 32'(code_errors), 32'd0);

        // Back-pressure: 0x3C held, 0xFF dropped.
        bus.byte_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 3);
        send_byte(8'hFF, 3);
        cycles(2);
        check("bp_data", 32'(bus.byte_data), 32'h3C);
        check("bp_valid", 32'(bus.byte_valid), 32'd1);
        check("bp_overrun", 32'(overrun), 32'd1);
        bus.byte_ready = 1'b1;
        cycles(1);
        check("bp_valid_drop", 32'(bus.byte_valid), 32'd0);

        // Violation on bit 3, then a clean 0x5A.
        send_bit(1'b0, 2);
        send_bit(1'b1, 2);
        send_bit(1'b0, 2);
        send_viol(1'b1, 2);
        cycles(2);
        check("viol_errors", 32'(code_errors), 32'd1);
        check("viol_valid", 32'(bus.byte_valid), 32'd0);
        check("viol_receiving", 32'(receiving), 32'd0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 2);
        cycles(3);

        // Idle timeout after 4 bits, then 0x81 aligned from bit 0.
        send_bit(1'b1, 4);
        send_bit(1'b0, 4);
        send_bit(1'b1, 4);
        send_bit(1'b1, 4);
        check("tmo_receiving_before", 32'(receiving), 32'd1);
        cycles(TIMEOUT);
        check("tmo_receiving", 32'(receiving), 32'd0);
        check("tmo_errors", 32'(code_errors), 32'd1);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 3);
        cycles(3);

        // Reset in the middle of a byte, then 0xC3.
        send_bit(1'b1, 2);
        send_bit(1'b1, 2);
        send_bit(1'b0, 2);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("mid_rst_receiving", 32'(receiving), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_errors", 32'(code_errors), 32'd0);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 2);
        cycles(3);

        // Completion on the same edge as acceptance.
        bus.byte_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_byte(8'h11, 2);
        v = 8'h22;
        for (int i = 0; i < 7; i++) send_bit(v[i], 2);
        digital_in       = v[7];
        manchester_clock = 1'b1;
        cycles(2);
        digital_in       = !v[7];
        manchester_clock = 1'b0;
        bus.byte_ready   = 1'b1;
        cycles(1);
        bus.byte_ready   = 1'b0;
        check("same_edge_valid", 32'(bus.byte_valid), 32'd1);
        check("same_edge_data", 32'(bus.byte_data), 32'h22);
        check("same_edge_overrun", 32'(overrun), 32'd0);
        cycles(1);
        bus.byte_ready = 1'b1;
        cycles(2);

        // Saturation of the violation counter.
        for (int i = 0; i < 255; i++) send_viol(1'b1, 1);
        check("sat_255", 32'(code_errors), 32'd255);
        send_viol(1'b0, 1);
        cycles(1);
        check("sat_hold", 32'(code_errors), 32'd255);

        cycles(4);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/manchester_byte_decoder.md
# manchester_byte_decoder

Decodes the Manchester-encoded input stream into bytes using the half-bit `manchester_clock` produced by the clock-recovery state machine. It sits directly downstream of that stage. It samples `digital_in` in each half of every bit period, checks that every bit has a mid-bit transition, and assembles bits LSB-first into bytes. Completed bytes go to the packet layer over a single-entry valid/ready interface, with overrun, code-violation and idle-timeout handling.

## Interface
- `TIMEOUT`, default 64: clock cycles without a `manchester_clock` toggle before a partial byte is discarded; valid range 2..255.
- `clock` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: reset, synchronous, active-high.
- `digital_in` input 1: line data, already synchronized to `clock`.
- `manchester_clock` input 1: recovered half-bit clock; it toggles once per half-bit.
- `byte_data` output 8: last completed byte; bit 0 is the first bit received.
- `byte_valid` output 1: `byte_data` holds an unconsumed byte.
- `byte_ready` input 1: consumer accepts the byte when `byte_valid && byte_ready`.
- `receiving` output 1: high whenever state is not HUNT.
- `overrun` output 1: sticky; a completed byte was dropped because the holding register was full.
- `code_errors` output 8: saturating count of Manchester code violations.

## Operation
- `mclk_q` is a register holding `manchester_clock` delayed one cycle.
- `toggle = manchester_clock ^ mclk_q`.
- A rising toggle (`toggle && manchester_clock`) marks the first half of a bit.
- A falling toggle (`toggle && !manchester_clock`) marks the second half of a bit.
- Reset values: all outputs 0, `mclk_q` = 0, state HUNT, shift register 0, bit counter 0, timeout counter 0.
- State HUNT:
  - On a rising toggle, capture `half_a <= digital_in` and go to WAIT_B.
  - Ignore falling toggles.
- State WAIT_B:
  - On a falling toggle, decode one bit from `half_a` and the current `digital_in`.
  - If `half_a != digital_in`: the bit value is `half_a` (high-then-low = 1). Shift it in at bit 7 of the shift register, shifting right, and increment the 3-bit bit counter.
  - If `half_a == digital_in`: this is a code violation. Increment `code_errors` (saturate at 255), clear the bit counter and shift register, and go to HUNT.
  - After a valid bit, go to WAIT_A.
- State WAIT_A:
  - On a rising toggle, capture `half_a` and go to WAIT_B.
- Byte completion: a valid bit that takes the bit counter from 7 to 0 completes a byte. The completed value is `{bit, shift[7:1]}`.
  - If `!byte_valid`, or `byte_valid && byte_ready` in the same cycle: load `byte_data` and set `byte_valid`.
  - Otherwise drop the byte and set `overrun`. `byte_data` is unchanged.
- Handshake: `byte_valid` clears the cycle after `byte_valid && byte_ready`, unless a new byte loads on that same edge. `byte_data` is stable while `byte_valid` is high and unaccepted.
- Idle timeout:
  - The 8-bit timeout counter clears on any toggle and increments otherwise while in WAIT_A or WAIT_B.
  - When it reaches `TIMEOUT - 1` with no toggle: discard the partial byte, clear the bit counter, go to HUNT, and clear the counter. `code_errors` is not incremented.
- `overrun` and `code_errors` clear only on reset.

## Timing
- Toggle detection lags `manchester_clock` by zero cycles: the toggle is seen in the first cycle `manchester_clock` differs from `mclk_q`.
- `digital_in` is sampled on the clock edge ending that cycle.
- Byte latency: `byte_valid` rises on the edge that processes the 8th falling toggle. It is visible the cycle after the 8th falling toggle is presented.
- Simultaneous toggle and timeout expiry in the same cycle: the toggle wins and the counter clears.
- Simultaneous byte completion and consumer acceptance: the new byte loads, `byte_valid` stays 1, and `overrun` is not set.
- A code violation on the 8th bit produces no byte and leaves `byte_valid` and `byte_data` untouched.
- Reset asserted mid-byte clears everything on that edge. The next byte requires a fresh rising toggle.
- Throughput: one byte per 16 toggles. The block places no minimum toggle spacing other than one clock cycle.

## Test plan
- Reset then idle: `reset` held high for 3 cycles, then released with `manchester_clock` constant → all outputs 0 for 100 cycles, state HUNT, `receiving` = 0.
- Single byte: `manchester_clock` toggles every 4 cycles, `byte_ready` = 1, line carries bits 1,0,1,0,0,1,0,1 → `byte_data` = 0xA5, `byte_valid` high exactly one cycle, `overrun` = 0, `code_errors` = 0.
- Back-pressure: send 0x3C then 0xFF with `byte_ready` = 0 → `byte_data` stays 0x3C, `overrun` = 1. After `byte_ready` rises, `byte_valid` drops the next cycle.
- Violation: line held high across both halves of bit 3 during a byte → `code_errors` = 1, no byte output. The following clean byte 0x5A is received correctly.
- Timeout: 4 valid bits sent, then `manchester_clock` frozen for 64 cycles → `receiving` falls, no byte output. The next full byte 0x81 decodes as 0x81, not shifted.
- Edge cases: 255 violations then 1 more → `code_errors` stays 255. Byte completion in the same cycle as acceptance → `byte_valid` stays high, `overrun` = 0. Reset mid-byte → next byte decodes cleanly.
